output_port_arbiter: RTL and testbench

Per-output-port scheduler for the router. Watches the head flit of every input buffer, selects one whose target field names this output port using round-robin, pops it from its buffer and presents it on a registered output with a valid/ready handshake toward the downstream link. One instance per router output port; the input buffers themselves have no arbitration.

---
 rtl/noc_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/output_port_arbiter.sv | 73 +++++++
 tb/tb_output_port_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Router-wide constants: flit layout and output port identifiers.
package noc_pkg;
    localparam int FLIT_W      = 23;
    localparam int PAYLOAD_LSB = 7;
    localparam int ADDR_LSB    = 3;
    localparam int TGT_W       = 3;

    typedef enum logic [TGT_W-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_id_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] winner,
    output logic          any_gnt
);
    always_comb begin
        gnt     = '0;
        winner  = '0;
        any_gnt = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any_gnt && req[idx]) begin
                any_gnt  = 1'b1;
                gnt[idx] = 1'b1;
                winner   = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port scheduler: round-robin over input buffer heads aimed at PORT_ID,
// feeding a single registered valid/ready stage toward the downstream link.
module output_port_arbiter #(
    parameter int                          N_IN    = 5,
    parameter int                          FLIT_W  = noc_pkg::FLIT_W,
    parameter logic [noc_pkg::TGT_W-1:0]   PORT_ID = noc_pkg::LOCAL,
    parameter int                          CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IN*FLIT_W-1:0]   in_flit,
    input  logic [N_IN-1:0]          in_nonempty,
    output logic [N_IN-1:0]          pop,
    output logic [FLIT_W-1:0]        out_flit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         sent_cnt
);
    import noc_pkg::*;

    localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [N_IN-1:0]   w_req;
    logic [N_IN-1:0]   w_gnt;
    logic [PW-1:0]     w_win;
    logic              w_any;
    logic              w_load;
    logic [PW-1:0]     r_ptr;
    logic [FLIT_W-1:0] r_flit;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt;

    for (genvar i = 0; i < N_IN; i++) begin : g_req
        assign w_req[i] = in_nonempty[i] && (in_flit[i*FLIT_W +: TGT_W] == PORT_ID);
    end

    rr_arbiter #(.N(N_IN), .IW(PW)) u_rr (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .winner  (w_win),
        .any_gnt (w_any)
    );

    // Loading is allowed when the stage is empty or its flit leaves this cycle.
    assign w_load = !r_valid || out_ready;
    assign pop    = (rst && w_load && w_any) ? w_gnt : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_flit  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_load) begin
                if (w_any) begin
                    r_flit  <= in_flit[w_win*FLIT_W +: FLIT_W];
                    r_valid <= 1'b1;
                    r_ptr   <= (w_win == PW'(N_IN-1)) ? '0 : w_win + 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end
            if (r_valid && out_ready && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_flit  = r_flit;
    assign out_valid = r_valid;
    assign sent_cnt  = r_cnt;
endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench: hand-computed pop vectors and counts; a monitor checks every
// downstream transfer against a queue filled by the stimulus.
module tb_output_port_arbiter;
    localparam int          N     = 5;
    localparam int          FW    = 23;
    localparam int          CW    = 4;
    localparam logic [2:0]  PID   = 3'd3;

    logic                clk = 1'b0;
    logic                rst;
    logic [N*FW-1:0]     in_flit;
    logic [N-1:0]        in_nonempty;
    logic [N-1:0]        pop;
    logic [FW-1:0]       out_flit;
    logic                out_valid;
    logic                out_ready;
    logic [CW-1:0]       sent_cnt;

    logic [FW-1:0]       fl [N];
    logic [FW-1:0]       q [$];
    int                  n_chk = 0;
    int                  n_pass = 0;

    always #5 clk = ~clk;

    always_comb begin
        in_flit = '0;
        for (int i = 0; i < N; i++) in_flit[i*FW +: FW] = fl[i];
    end

    output_port_arbiter #(.N_IN(N), .FLIT_W(FW), .PORT_ID(PID), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_nonempty(in_nonempty),
        .pop(pop), .out_flit(out_flit), .out_valid(out_valid),
        .out_ready(out_ready), .sent_cnt(sent_cnt)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    function automatic logic [FW-1:0] mk(input int i, input logic [2:0] tgt);
        return {16'hA000 + 16'(i), 4'(i), tgt};
    endfunction

    task automatic set_default();
        for (int i = 0; i < N; i++) fl[i] = mk(i, PID);
    endtask

    // One cycle: check pop (and optionally sent_cnt) mid-cycle, log the expected flit.
    task automatic step(input logic [N-1:0] ep, input int pi, input int ec);
        @(negedge clk);
        chk("pop", 32'(pop), 32'(ep));
        if (ec >= 0) chk("sent_cnt", 32'(sent_cnt), 32'(ec));
        if (pi >= 0) q.push_back(fl[pi]);
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_xfer", 32'(out_flit), 32'hFFFF_FFFF);
                else chk("out_flit", 32'(out_flit), 32'(q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b0; out_ready = 1'b1; in_nonempty = '1;
        set_default();
        repeat (2) begin
            @(negedge clk);
            chk("rst_pop", 32'(pop), 0);
            chk("rst_valid", 32'(out_valid), 0);
        end
        chk("rst_flit", 32'(out_flit), 0);
        chk("rst_cnt", 32'(sent_cnt), 0);
        @(posedge clk); #1 rst = 1'b1;

        // Round-robin across all five buffers
        for (int k = 0; k < 6; k++) step(5'(1 << (k % N)), k % N, -1);

        // Single requester, buffer 3
        in_nonempty = 5'b01000; fl[3] = 23'h1A2B3B;
        step(5'b01000, 3, 5);
        step(5'b01000, 3, -1);
        step(5'b01000, 3, -1);
        step(5'b01000, 3, 8);

        // Backpressure with everyone requesting
        out_ready = 1'b0; set_default(); in_nonempty = '1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_pop", 32'(pop), 0);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_flit", 32'(out_flit), 32'h1A2B3B);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        step(5'b10000, 4, 9);
        step(5'b00001, 0, -1);

        // Target filtering
        fl[0] = mk(0, PID + 3'd1); fl[2] = mk(2, PID + 3'd1); fl[4] = mk(4, 3'd7);
        in_nonempty = 5'b10101;
        step(5'b00000, -1, -1);
        repeat (2) begin
            @(negedge clk);
            chk("filt_valid", 32'(out_valid), 0);
            @(posedge clk); #1;
            step(5'b00000, -1, -1);
        end
        fl[2] = mk(2, PID);
        step(5'b00100, 2, -1);

        // Drain to empty, then pointer must resume at 3
        in_nonempty = '0;
        step(5'b00000, -1, -1);
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        set_default(); in_nonempty = 5'b01011;
        step(5'b01000, 3, -1);
        step(5'b00001, 0, -1);

        // Async reset mid-burst
        in_nonempty = '1;
        @(negedge clk);
        chk("pre_rst_pop", 32'(pop), 32'(5'b00010));
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_cnt", 32'(sent_cnt), 0);
        chk("arst_pop", 32'(pop), 0);
        chk("arst_flit", 32'(out_flit), 0);
        q.delete();
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        step(5'b00001, 0, 0);
        step(5'b00010, 1, 0);
        step(5'b00100, 2, 1);

        // Counter saturation
        in_nonempty = 5'b01000;
        repeat (20) step(5'b01000, 3, -1);
        in_nonempty = '0;
        repeat (3) step(5'b00000, -1, -1);
        step(5'b00000, -1, 15);
        chk("queue_empty", 32'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
